// File: rtl/logunits_pkg.sv
// rtl/logunits_pkg.sv - shared types and constants for the logic units
package logunits_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNTW      = $clog2(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rol_state_t;

endpackage

// File: rtl/rol_step.sv
// rtl/rol_step.sv - combinational one-bit rotate-left with bit-out
module rol_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             bout
);

    assign dout = {din[WIDTH-2:0], din[WIDTH-1]};
    assign bout = din[WIDTH-1];

endmodule

// File: rtl/rol_iter.sv
// rtl/rol_iter.sv - multicycle rotate-left, one bit per clock, start/busy/done
module rol_iter
    import logunits_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Ain,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Aout,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    rol_state_t      state_q, state_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   amt;
    logic [WIDTH-1:0] rot_word;
    logic            rot_bit;
    logic            accept;

    // Amount is taken mod WIDTH; the upper shamt bits are intentionally dropped.
    assign amt = shamt[CW-1:0];

    logic unused_shamt_hi;
    assign unused_shamt_hi = ^shamt[SHW-1:CW];

    assign accept = start && (state_q != RUN);
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);

    rol_step #(.WIDTH(WIDTH)) u_step (
        .din  (Aout),
        .dout (rot_word),
        .bout (rot_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (amt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = (amt == '0) ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Aout    <= '0;
            cout    <= 1'b0;
            count_q <= '0;
        end else if (accept) begin
            Aout    <= Ain;
            cout    <= 1'b0;
            count_q <= amt;
        end else if (state_q == RUN) begin
            Aout    <= rot_word;
            cout    <= rot_bit;
            count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_rol_iter.sv
// tb/tb_rol_iter.sv - directed self-checking bench for rol_iter
module tb_rol_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] Ain;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [15:0] Aout;
    logic        cout;

    int checks = 0;
    int errors = 0;

    rol_iter #(.WIDTH(16), .SHW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Ain   (Ain),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .Aout  (Aout),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepted request; returns during cycle 1 after the accept edge.
    task automatic accept_op(input logic [15:0] a, input logic [4:0] s);
        Ain   = a;
        shamt = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Advances until done or a cycle budget expires; counts busy cycles seen.
    task automatic wait_done(input int c0, output int cyc, output int busy_cycles);
        cyc = c0;
        busy_cycles = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; Ain = 16'h0; shamt = 5'd0;
        tick(); tick();
        checks++;
        if ({busy, done, cout, Aout} !== 19'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b cout=%b Aout=%h, required all 0", busy, done, cout, Aout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rot1();
        int cyc, bc;
        accept_op(16'h8001, 5'd1);
        wait_done(1, cyc, bc);
        checks++;
        if (cyc !== 2 || bc !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rot1_timing: done_cycle=%0d busy_cycles=%0d busy=%b, required 2 1 0", cyc, bc, busy);
        end
        checks++;
        if (Aout !== 16'h0003 || cout !== 1'b1) begin
            errors++;
            $display("FAIL rot1_result: Aout=%h cout=%b, required 0003 1", Aout, cout);
        end
        tick();
    endtask

    task automatic test_rot4();
        int cyc, bc;
        accept_op(16'h1234, 5'd4);
        wait_done(1, cyc, bc);
        checks++;
        if (cyc !== 5 || bc !== 4) begin
            errors++;
            $display("FAIL rot4_timing: done_cycle=%0d busy_cycles=%0d, required 5 4", cyc, bc);
        end
        checks++;
        if (Aout !== 16'h2341 || cout !== 1'b1) begin
            errors++;
            $display("FAIL rot4_result: Aout=%h cout=%b, required 2341 1", Aout, cout);
        end
        tick();
        checks++;
        if (done !== 1'b0 || Aout !== 16'h2341) begin
            errors++;
            $display("FAIL rot4_hold: done=%b Aout=%h, required 0 2341", done, Aout);
        end
    endtask

    task automatic test_zero_amount();
        int cyc, bc;
        logic [4:0] amts [2];
        amts[0] = 5'b10000;
        amts[1] = 5'b00000;
        for (int i = 0; i < 2; i++) begin
            accept_op(16'h1234, amts[i]);
            wait_done(1, cyc, bc);
            checks++;
            if (cyc !== 1 || bc !== 0) begin
                errors++;
                $display("FAIL zero_timing[%0d]: done_cycle=%0d busy_cycles=%0d, required 1 0", i, cyc, bc);
            end
            checks++;
            if (Aout !== 16'h1234 || cout !== 1'b0) begin
                errors++;
                $display("FAIL zero_result[%0d]: Aout=%h cout=%b, required 1234 0", i, Aout, cout);
            end
            tick();
        end
    endtask

    task automatic test_rot15_ignore_start();
        int cyc, bc;
        accept_op(16'h1234, 5'd31);
        tick(); tick(); tick();
        Ain = 16'hFFFF; shamt = 5'd2; start = 1'b1;
        tick();
        start = 1'b0; Ain = 16'h0000; shamt = 5'd0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_state: busy=%b done=%b, required 1 0", busy, done);
        end
        wait_done(5, cyc, bc);
        checks++;
        if (cyc !== 16) begin
            errors++;
            $display("FAIL rot15_timing: done_cycle=%0d, required 16", cyc);
        end
        checks++;
        if (Aout !== 16'h091A || cout !== 1'b0) begin
            errors++;
            $display("FAIL rot15_result: Aout=%h cout=%b, required 091a 0", Aout, cout);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        accept_op(16'h0001, 5'd3);
        wait_done(1, cyc, bc);
        checks++;
        if (cyc !== 4 || Aout !== 16'h0008) begin
            errors++;
            $display("FAIL b2b_opA: done_cycle=%0d Aout=%h, required 4 0008", cyc, Aout);
        end
        Ain = 16'hF000; shamt = 5'd4; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_handoff: done=%b busy=%b, required 0 1", done, busy);
        end
        wait_done(5, cyc, bc);
        checks++;
        if (cyc !== 9 || Aout !== 16'h000F || cout !== 1'b1) begin
            errors++;
            $display("FAIL b2b_opB: done_cycle=%0d Aout=%h cout=%b, required 9 000f 1", cyc, Aout, cout);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int cyc, bc;
        accept_op(16'hABCD, 5'd8);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, cout, Aout} !== 19'h0) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b done=%b cout=%b Aout=%h, required all 0", busy, done, cout, Aout);
        end
        accept_op(16'hABCD, 5'd8);
        wait_done(1, cyc, bc);
        checks++;
        if (cyc !== 9 || Aout !== 16'hCDAB || cout !== 1'b1) begin
            errors++;
            $display("FAIL reset_rerun: done_cycle=%0d Aout=%h cout=%b, required 9 cdab 1", cyc, Aout, cout);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_rot1();
        test_rot4();
        test_zero_amount();
        test_rot15_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
